// File: rtl/shift_job_sched_pkg.sv
// Shared types and default sizing for the shift job scheduler.
package shift_job_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AMT_W   = $clog2(DEF_WIDTH);
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/shift_job_sched_if.sv
// Requester-side bus of the scheduler: flattened job posts in, tagged results out.
interface shift_job_sched_if #(
  parameter int WIDTH   = shift_job_pkg::DEF_WIDTH,
  parameter int NUM_REQ = shift_job_pkg::DEF_NUM_REQ,
  parameter int AMT_W   = $clog2(WIDTH),
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ*AMT_W-1:0] req_amt;
  logic [NUM_REQ-1:0]       gnt;
  logic                     out_valid;
  logic [WIDTH-1:0]         out_data;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  modport master (
    output req, req_data, req_amt,
    input  gnt, out_valid, out_data, out_id, busy
  );

  modport slave (
    input  req, req_data, req_amt,
    output gnt, out_valid, out_data, out_id, busy
  );

endinterface

// File: rtl/shift_job_sched_rr_arbiter.sv
// Combinational round-robin pick: search starts just after ptr and wraps.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               valid
);

  // cand[k] is the requester examined k-th in this cycle's search order
  logic [ID_W-1:0] cand [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ID_W'((32'(ptr) + 32'(gi) + 32'd1) % 32'(NUM_REQ));
    end
  endgenerate

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
    gnt = valid ? (NUM_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/shift_job_sched.sv
// Round-robin job scheduler sharing one rotate-left-by-one datapath among
// NUM_REQ requesters; all state updates on the falling edge of clk.
module shift_job_sched
  import shift_job_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AMT_W   = $clog2(WIDTH),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  shift_job_sched_if.slave bus
);

  state_t             state_reg;
  logic [WIDTH-1:0]   sr_reg;
  logic [AMT_W-1:0]   cnt_reg;
  logic [ID_W-1:0]    ptr_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic [ID_W-1:0]    out_id_reg;
  logic               busy_reg;

  logic [NUM_REQ-1:0] win_oh;
  logic [ID_W-1:0]    win_idx;
  logic               win_valid;
  logic [WIDTH-1:0]   win_data;
  logic [AMT_W-1:0]   win_amt;
  logic [WIDTH-1:0]   sr_rot;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .gnt   (win_oh),
    .idx   (win_idx),
    .valid (win_valid)
  );

  assign win_data = bus.req_data[win_idx*WIDTH +: WIDTH];
  assign win_amt  = bus.req_amt[win_idx*AMT_W +: AMT_W];
  assign sr_rot   = {sr_reg[WIDTH-2:0], sr_reg[WIDTH-1]};

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      sr_reg        <= '0;
      cnt_reg       <= '0;
      ptr_reg       <= ID_W'(NUM_REQ - 1);
      gnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_id_reg    <= '0;
      busy_reg      <= 1'b0;
    end else begin
      gnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            sr_reg     <= win_data;
            cnt_reg    <= win_amt;
            out_id_reg <= win_idx;
            ptr_reg    <= win_idx;
            gnt_reg    <= win_oh;
            busy_reg   <= 1'b1;
            // A zero-length job skips the datapath and is presented next cycle
            if (win_amt != '0) begin
              state_reg <= SHIFT;
            end else begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              out_data_reg  <= win_data;
            end
          end
        end
        SHIFT: begin
          sr_reg  <= sr_rot;
          cnt_reg <= cnt_reg - AMT_W'(1);
          if (cnt_reg == AMT_W'(1)) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            out_data_reg  <= sr_rot;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.busy      = busy_reg;

endmodule

// File: tb/tb_shift_job_sched.sv
// Self-checking bench for shift_job_sched: directed cases plus randomized job
// streams checked against a round-robin / rotate reference model.
module tb_shift_job_sched;
  import shift_job_pkg::*;

  localparam int W  = 32;
  localparam int NR = 4;
  localparam int AW = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  shift_job_sched_if #(.WIDTH(W), .NUM_REQ(NR), .AMT_W(AW), .ID_W(IW)) bus ();

  shift_job_sched #(.WIDTH(W), .NUM_REQ(NR), .AMT_W(AW), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: the requesters' current jobs and the rr pointer
  int              ptr_m;
  logic [NR-1:0]   mask;
  logic [W-1:0]    jd [NR];
  logic [AW-1:0]   ja [NR];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_data[i*W +: W]   = jd[i];
      bus.req_amt[i*AW +: AW]  = ja[i];
    end
    bus.req = mask;
  endtask

  function automatic int pick(input int p, input logic [NR-1:0] m);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (p + k) % NR;
      if (m[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] rotl(input logic [W-1:0] d, input int a);
    if (a == 0) return d;
    return (d << a) | (d >> (W - a));
  endfunction

  task automatic test_reset();
    mask = '0;
    for (int i = 0; i < NR; i++) begin
      jd[i] = '0;
      ja[i] = '0;
    end
    drive();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    checks++; if (bus.gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
    checks++; if (bus.out_id !== '0) begin errors++; $display("FAIL reset_out_id: got %0d want 0", bus.out_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    ptr_m = NR - 1;
    @(posedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.gnt !== '0) begin errors++; $display("FAIL idle_no_req: busy %b gnt %b want 0 0", bus.busy, bus.gnt); end
  endtask

  task automatic test_directed();
    int            id_t [4] = '{0, 2, 1, 3};
    logic [W-1:0]  d_t  [4] = '{32'h0000_0001, 32'hDEAD_BEEF, 32'h8000_0001, 32'h0000_0001};
    int            a_t  [4] = '{4, 0, 1, 31};
    logic [W-1:0]  e_t  [4] = '{32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0003, 32'h8000_0000};
    for (int c = 0; c < 4; c++) begin
      int waited;
      int bad;
      logic [NR-1:0] exp_g;
      mask = '0;
      mask[id_t[c]] = 1'b1;
      jd[id_t[c]] = d_t[c];
      ja[id_t[c]] = AW'(a_t[c]);
      drive();
      waited = 0;
      do begin @(posedge clk); waited++; end while (bus.gnt === '0 && waited < 80);
      exp_g = '0;
      exp_g[id_t[c]] = 1'b1;
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL dir_gnt[%0d]: got %b want %b", c, bus.gnt, exp_g); end
      bad = (bus.busy !== 1'b1) ? 1 : 0;
      mask = '0;
      drive();
      ptr_m = id_t[c];
      for (int j = 1; j <= a_t[c]; j++) begin
        @(posedge clk);
        if (j < a_t[c] && (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.gnt !== '0)) bad = 1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL dir_shift_phase[%0d]: early out_valid, stray gnt or busy low", c); end
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dir_out_valid[%0d]: got %b want 1", c, bus.out_valid); end
      checks++; if (bus.out_data !== e_t[c]) begin errors++; $display("FAIL dir_out_data[%0d]: got %h want %h", c, bus.out_data, e_t[c]); end
      checks++; if (bus.out_id !== IW'(id_t[c])) begin errors++; $display("FAIL dir_out_id[%0d]: got %0d want %0d", c, bus.out_id, id_t[c]); end
      $display("directed job id=%0d data=%h amt=%0d result=%h", id_t[c], d_t[c], a_t[c], bus.out_data);
      @(posedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dir_end[%0d]: out_valid %b busy %b want 0 0", c, bus.out_valid, bus.busy); end
      checks++; if (bus.out_data !== e_t[c]) begin errors++; $display("FAIL dir_hold[%0d]: got %h want %h", c, bus.out_data, e_t[c]); end
    end
  endtask

  // mode 0: all four held, amt=2; mode 1: req 0 and 2 held; mode 2: random masks
  task automatic test_stream(input int mode, input int ncap);
    for (int i = 0; i < NR; i++) begin
      jd[i] = $urandom;
      ja[i] = (mode == 0) ? AW'(2) : AW'($urandom_range(0, W - 1));
    end
    case (mode)
      0: mask = 4'b1111;
      1: mask = 4'b0101;
      default: mask = NR'($urandom_range(1, (1 << NR) - 1));
    endcase
    drive();
    for (int c = 0; c < ncap; c++) begin
      int waited;
      int win;
      int k;
      int bad;
      logic [NR-1:0] exp_g;
      logic [W-1:0] exp_d;
      win = pick(ptr_m, mask);
      waited = 0;
      do begin @(posedge clk); waited++; end while (bus.gnt === '0 && waited < 80);
      exp_g = '0;
      exp_g[win] = 1'b1;
      checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL stream%0d_gnt[%0d]: got %b want %b", mode, c, bus.gnt, exp_g); end
      if (c > 0) begin
        checks++; if (waited != 1) begin errors++; $display("FAIL stream%0d_gap[%0d]: capture %0d cycles after idle, want 1", mode, c, waited); end
      end
      ptr_m = win;
      k = int'(ja[win]);
      exp_d = rotl(jd[win], k);
      bad = (k > 0 && bus.out_valid !== 1'b0) ? 1 : 0;
      jd[win] = $urandom;
      ja[win] = (mode == 0) ? AW'(2) : AW'($urandom_range(0, W - 1));
      if (mode == 2) begin
        mask[win] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) mask = mask | NR'($urandom_range(0, (1 << NR) - 1));
        if (mask == '0) mask = NR'($urandom_range(1, (1 << NR) - 1));
      end
      drive();
      for (int j = 1; j <= k; j++) begin
        @(posedge clk);
        if (j < k && (bus.out_valid !== 1'b0 || bus.gnt !== '0 || bus.busy !== 1'b1)) bad = 1;
        if (j == 1 && bus.gnt !== '0) bad = 1;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stream%0d_shift[%0d]: early out_valid, stray gnt or busy low", mode, c); end
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_id !== IW'(win)) begin
        errors++;
        $display("FAIL stream%0d_result[%0d]: got v=%b d=%h id=%0d want v=1 d=%h id=%0d", mode, c, bus.out_valid, bus.out_data, bus.out_id, exp_d, win);
      end
      $display("stream%0d job %0d id=%0d amt=%0d result=%h", mode, c, win, k, bus.out_data);
      @(posedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== '0) begin
        errors++;
        $display("FAIL stream%0d_idle[%0d]: v=%b busy=%b gnt=%b want 0 0 0", mode, c, bus.out_valid, bus.busy, bus.gnt);
      end
    end
    mask = '0;
    drive();
  endtask

  task automatic test_reset_mid();
    int waited;
    int seen_ov;
    int k;
    logic [W-1:0] exp_d;
    mask = 4'b0010;
    jd[1] = $urandom;
    ja[1] = AW'(5);
    drive();
    waited = 0;
    do begin @(posedge clk); waited++; end while (bus.gnt === '0 && waited < 80);
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_gnt1: got %b want 0010", bus.gnt); end
    mask = '0;
    drive();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    checks++; if (bus.out_valid !== 1'b0 || bus.gnt !== '0) begin errors++; $display("FAIL rstmid_strobes: v=%b gnt=%b want 0 0", bus.out_valid, bus.gnt); end
    @(posedge clk);
    rst = 1'b0;
    ptr_m = NR - 1;
    mask = 4'b1001;
    jd[0] = $urandom;
    jd[3] = $urandom;
    ja[0] = AW'($urandom_range(1, W - 1));
    ja[3] = AW'($urandom_range(0, W - 1));
    drive();
    seen_ov = 0;
    waited = 0;
    do begin
      @(posedge clk);
      waited++;
      if (bus.out_valid !== 1'b0) seen_ov = 1;
    end while (bus.gnt === '0 && waited < 80);
    checks++; if (seen_ov != 0) begin errors++; $display("FAIL rstmid_dropped: out_valid seen for the dropped job"); end
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_gnt2: got %b want 0001", bus.gnt); end
    ptr_m = 0;
    k = int'(ja[0]);
    exp_d = rotl(jd[0], k);
    mask = '0;
    drive();
    for (int j = 1; j <= k; j++) @(posedge clk);
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d || bus.out_id !== '0) begin
      errors++;
      $display("FAIL rstmid_result: got v=%b d=%h id=%0d want v=1 d=%h id=0", bus.out_valid, bus.out_data, bus.out_id, exp_d);
    end
    $display("post-reset job id=0 amt=%0d result=%h", k, bus.out_data);
    @(posedge clk);
  endtask

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_amt  = '0;
    test_reset();
    test_directed();
    test_reset();
    test_stream(0, 5);
    test_stream(1, 6);
    test_stream(2, 40);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
